wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single write port of the predicate, general and float register files between two requesters.
- Requester 1 is the in-order pipeline writeback stage. Requester 2 is the long-latency unit (div/mod/FP), which uses a valid/ready handshake.
- The pipeline has priority. A wait counter guarantees the long-latency unit a slot within MAX_WAIT cycles, using a one-cycle pipeline stall plus a one-entry skid buffer.
- Outputs drive the decode stage's rw / Pz_id / Pz / Rz_id / Rz / Fz_id / Fz inputs directly.

Parameters:
- MAX_WAIT, 4, maximum consecutive cycles the long-latency unit may be refused before it is force-granted; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst, synchronous, active-high.
- pipe_rw  in  3  pipeline write enables; bit0 preg, bit1 greg, bit2 freg.
- pipe_id  in  4  pipeline destination register index.
- pipe_data  in  32  pipeline write data.
- lu_valid  in  1  long-latency unit has a result.
- lu_rw  in  3  long-latency unit write enables, same encoding as pipe_rw.
- lu_id  in  4  long-latency unit destination index.
- lu_data  in  32  long-latency unit write data.
- lu_ready  out  1  long-latency unit request accepted this cycle.
- pipe_stall  out  1  pipeline must hold its writeback inputs this cycle.
- rw  out  3  register file write enables.
- Pz_id  out  2  predicate destination.
- Pz  out  1  predicate value.
- Rz_id  out  4  general register destination.
- Rz  out  32  general register data.
- Fz_id  out  4  float register destination.
- Fz  out  32  float register data.

Behaviour:
- Pipeline request: pipe_req = |pipe_rw. pipe_req is ignored while pipe_stall=1.
- Long-latency transfer: occurs when lu_valid && lu_ready.
- lu_ready is combinational from state, pipe_req and wait_cnt. It never depends on lu_valid.
- States:
  - NORMAL, the reset state.
  - DRAIN, which lasts exactly one cycle and asserts pipe_stall=1 (Moore output).
- NORMAL grant rules:
  - If pipe_req and wait_cnt < MAX_WAIT: grant the pipeline; lu_ready=0.
  - If pipe_req and wait_cnt == MAX_WAIT: assert lu_ready=1. If lu_valid, grant the long-latency unit, capture the pipeline request into the skid buffer, and go to DRAIN. If !lu_valid, grant the pipeline and stay in NORMAL.
  - If !pipe_req: assert lu_ready=1 and grant the long-latency unit if lu_valid.
- DRAIN:
  - Grant the skid buffer entry, clear the skid, return to NORMAL.
  - lu_ready=0.
  - The pipeline holds the instruction it presents during DRAIN and re-presents it in the following NORMAL cycle; no request is lost or duplicated.
- wait_cnt:
  - Width 4, saturates at MAX_WAIT.
  - Increments when lu_valid && !lu_ready.
  - Clears on a long-latency transfer or when lu_valid=0.
- Write port output:
  - Registered, 1-cycle latency from grant.
  - On grant: rw <= granted rw, Pz_id <= id[1:0], Pz <= data[0], Rz_id <= id, Rz <= data, Fz_id <= id, Fz <= data.
  - With no grant, rw <= 0; id/data outputs hold their previous values.
- Ordering: writes leave in grant order. Destination collisions between requesters are not checked; the later grant wins.
- Reset (including mid-operation, in either state):
  - Next edge: state=NORMAL, skid empty and discarded, wait_cnt=0.
  - pipe_stall=0, rw=0, Pz_id=0, Pz=0, Rz_id=0, Rz=0, Fz_id=0, Fz=0.
  - lu_ready is evaluated from the reset state.
- Invariants:
  - Never more than one write per cycle.
  - The skid is occupied only in DRAIN.
  - pipe_stall never asserts two consecutive cycles.

Test Plan:
- Reset: assert rst for 2 cycles with pipe_rw=3'b010 → rw=0, pipe_stall=0, Rz=0. In the cycle after release, lu_ready=1 if pipe_rw=0.
- Pipeline only: pipe_rw=3'b010, pipe_id=5, pipe_data=0x1234 for 1 cycle → next cycle rw=3'b010, Rz_id=5, Rz=0x1234. The cycle after, rw=0.
- Long-latency only: lu_valid=1, lu_rw=3'b100, lu_id=9, lu_data=0x3F800000, pipe_rw=0 → lu_ready=1 the same cycle; next cycle rw=3'b100, Fz_id=9, Fz=0x3F800000.
- Starvation, MAX_WAIT=4:
  - Stimulus: pipe_rw=3'b010 every cycle with ids 1,2,3,… and lu_valid held.
  - Expected: lu_ready=0 for 4 cycles, then 1 on the 5th. The next cycle's output is the long-latency write, and pipe_stall=1 in that cycle.
  - The following output is the skid entry (the 5th pipeline id), then pipeline ids continue consecutively with none missing or doubled.
- Predicate write: pipe_rw=3'b001, pipe_id=4'b0110, pipe_data=1 → rw=3'b001, Pz_id=2'b10, Pz=1.
- Reset in DRAIN: force DRAIN as in the starvation scenario, then assert rst in the DRAIN cycle → next cycle rw=0 and pipe_stall=0, and the skid entry is never written.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback stage has priority,
// the long-latency unit is force-granted after MAX_WAIT refused cycles, and the
// displaced pipeline write is parked in a one-entry skid for one stall cycle.
//
// state  | meaning
// NORMAL | pipeline has priority; long-latency unit is served when idle or starved
// DRAIN  | pipeline stalled for one cycle while the skid entry is written
module wb_port_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pipe_rw,
    input  logic [3:0]  pipe_id,
    input  logic [31:0] pipe_data,
    input  logic        lu_valid,
    input  logic [2:0]  lu_rw,
    input  logic [3:0]  lu_id,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        pipe_stall,
    output logic [2:0]  rw,
    output logic [1:0]  Pz_id,
    output logic        Pz,
    output logic [3:0]  Rz_id,
    output logic [31:0] Rz,
    output logic [3:0]  Fz_id,
    output logic [31:0] Fz
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic [2:0]  skid_rw;
    logic [3:0]  skid_id;
    logic [31:0] skid_data;

    logic        pipe_req;
    logic        grant;
    logic [2:0]  g_rw;
    logic [3:0]  g_id;
    logic [31:0] g_data;
    logic        skid_load;

    // Pipeline requests are ignored while it is being stalled.
    assign pipe_req   = (|pipe_rw) && (state == NORMAL);
    assign pipe_stall = (state == DRAIN);

    // Grant selection, lu_ready and next state.
    always_comb begin
        state_nxt = state;
        lu_ready  = 1'b0;
        grant     = 1'b0;
        g_rw      = 3'b000;
        g_id      = pipe_id;
        g_data    = pipe_data;
        skid_load = 1'b0;
        case (state)
            NORMAL: begin
                if (pipe_req && wait_cnt < MAX_W) begin
                    grant = 1'b1;
                    g_rw  = pipe_rw;
                end else if (pipe_req) begin
                    lu_ready = 1'b1;
                    grant    = 1'b1;
                    if (lu_valid) begin
                        g_rw      = lu_rw;
                        g_id      = lu_id;
                        g_data    = lu_data;
                        skid_load = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        g_rw = pipe_rw;
                    end
                end else begin
                    lu_ready = 1'b1;
                    if (lu_valid) begin
                        grant  = 1'b1;
                        g_rw   = lu_rw;
                        g_id   = lu_id;
                        g_data = lu_data;
                    end
                end
            end
            DRAIN: begin
                grant     = 1'b1;
                g_rw      = skid_rw;
                g_id      = skid_id;
                g_data    = skid_data;
                state_nxt = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= NORMAL;
        else     state <= state_nxt;
    end

    // Starvation counter: counts refused cycles, saturating at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (rst || !lu_valid || lu_ready) wait_cnt <= 4'd0;
        else if (wait_cnt < MAX_W)        wait_cnt <= wait_cnt + 4'd1;
    end

    // Skid buffer: holds the displaced pipeline write only across DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_rw   <= 3'b000;
            skid_id   <= 4'd0;
            skid_data <= 32'd0;
        end else if (skid_load) begin
            skid_rw   <= pipe_rw;
            skid_id   <= pipe_id;
            skid_data <= pipe_data;
        end else if (state == DRAIN) begin
            skid_rw   <= 3'b000;
        end
    end

    // Registered write port; id/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rw    <= 3'b000;
            Pz_id <= 2'd0;
            Pz    <= 1'b0;
            Rz_id <= 4'd0;
            Rz    <= 32'd0;
            Fz_id <= 4'd0;
            Fz    <= 32'd0;
        end else if (grant) begin
            rw    <= g_rw;
            Pz_id <= g_id[1:0];
            Pz    <= g_data[0];
            Rz_id <= g_id;
            Rz    <= g_data;
            Fz_id <= g_id;
            Fz    <= g_data;
        end else begin
            rw    <= 3'b000;
        end
    end

endmodule
